button_led_ctrl: RTL and testbench

- Consumes the one-cycle, synchronized button-press pulses produced by the input synchronizer stage.
- Rejects pulses that arrive during a per-button lockout window, which debounces mechanical bounce.
- Each button steps its own LED through a mode cycle: OFF -> ON -> BLINK -> OFF.
- Drives the board LEDs directly. Single clock domain, same clock as the synchronizer.

---
 rtl/button_led_ctrl.sv | 132 +++++++++++++
 tb/tb_button_led_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/button_led_ctrl.sv
// Per-button debounced mode stepper (OFF -> ON -> BLINK -> OFF) driving board LEDs.
// Optional feature: define LED_PRESS_COUNT_EN to add the per-button accepted-press counters.
module button_led_ctrl #(
   parameter int BUTTON_COUNT   = 1,
   parameter int LOCKOUT_CYCLES = 5_000_000,
   parameter int BLINK_CYCLES   = 12_500_000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [BUTTON_COUNT-1:0]   button_pressed,
   output logic [BUTTON_COUNT-1:0]   led,
   output logic [2*BUTTON_COUNT-1:0] mode,
`ifdef LED_PRESS_COUNT_EN
   output logic [8*BUTTON_COUNT-1:0] press_count,
`endif
   output logic [BUTTON_COUNT-1:0]   press_ignored
);

   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_ILL   = 2'b11
   } mode_e;

   mode_e                   mode_q [BUTTON_COUNT];
   mode_e                   mode_d [BUTTON_COUNT];
   logic [LW-1:0]           lock_q [BUTTON_COUNT];
   logic [LW-1:0]           lock_d [BUTTON_COUNT];
   logic [BW-1:0]           presc_q, presc_d;
   logic                    phase_q, phase_d;
   logic [BUTTON_COUNT-1:0] led_q, led_d;
   logic [BUTTON_COUNT-1:0] ign_q, ign_d;
   logic [BUTTON_COUNT-1:0] accept_s;
`ifdef LED_PRESS_COUNT_EN
   logic [7:0]              cnt_q [BUTTON_COUNT];
   logic [7:0]              cnt_d [BUTTON_COUNT];
`endif

   // Next-state logic: shared blink prescaler plus per-button lockout, mode and LED.
   always_comb begin
      if (presc_q == BW'(BLINK_CYCLES - 1)) begin
         presc_d = '0;
         phase_d = ~phase_q;
      end else begin
         presc_d = presc_q + BW'(1);
         phase_d = phase_q;
      end

      accept_s = '0;
      ign_d    = '0;
      led_d    = '0;
      for (int i = 0; i < BUTTON_COUNT; i++) begin
         accept_s[i] = button_pressed[i] && (lock_q[i] == LW'(0));
         ign_d[i]    = button_pressed[i] && (lock_q[i] != LW'(0));

         // A rejected press lets the running lockout continue rather than restarting it.
         if (accept_s[i]) begin
            lock_d[i] = LW'(LOCKOUT_CYCLES - 1);
         end else if (lock_q[i] != LW'(0)) begin
            lock_d[i] = lock_q[i] - LW'(1);
         end else begin
            lock_d[i] = lock_q[i];
         end

         case (mode_q[i])
            MODE_OFF:   mode_d[i] = accept_s[i] ? MODE_ON    : MODE_OFF;
            MODE_ON:    mode_d[i] = accept_s[i] ? MODE_BLINK : MODE_ON;
            MODE_BLINK: mode_d[i] = accept_s[i] ? MODE_OFF   : MODE_BLINK;
            default:    mode_d[i] = MODE_OFF;
         endcase

         case (mode_q[i])
            MODE_OFF:   led_d[i] = 1'b0;
            MODE_ON:    led_d[i] = 1'b1;
            MODE_BLINK: led_d[i] = phase_q;
            default:    led_d[i] = 1'b0;
         endcase

`ifdef LED_PRESS_COUNT_EN
         if (accept_s[i]) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end else begin
            cnt_d[i] = cnt_q[i];
         end
`endif
      end
   end

   // State registers; synchronous reset wins over any coincident press.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= '0;
         phase_q <= 1'b0;
         led_q   <= '0;
         ign_q   <= '0;
         for (int i = 0; i < BUTTON_COUNT; i++) begin
            mode_q[i] <= MODE_OFF;
            lock_q[i] <= '0;
`ifdef LED_PRESS_COUNT_EN
            cnt_q[i]  <= 8'd0;
`endif
         end
      end else begin
         presc_q <= presc_d;
         phase_q <= phase_d;
         led_q   <= led_d;
         ign_q   <= ign_d;
         for (int i = 0; i < BUTTON_COUNT; i++) begin
            mode_q[i] <= mode_d[i];
            lock_q[i] <= lock_d[i];
`ifdef LED_PRESS_COUNT_EN
            cnt_q[i]  <= cnt_d[i];
`endif
         end
      end
   end

   assign led           = led_q;
   assign press_ignored = ign_q;

   for (genvar g = 0; g < BUTTON_COUNT; g++) begin : g_out
      assign mode[2*g +: 2] = mode_q[g];
`ifdef LED_PRESS_COUNT_EN
      assign press_count[8*g +: 8] = cnt_q[g];
`endif
   end

endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed self-checking bench for button_led_ctrl (2 buttons, lockout 4, blink 3).
module tb_button_led_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] button_pressed = 2'b00;
   logic [1:0] led;
   logic [3:0] mode;
   logic [1:0] press_ignored;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;   // edges since the last edge sampled with reset high

   always #5 clock = ~clock;

   button_led_ctrl #(.BUTTON_COUNT(2), .LOCKOUT_CYCLES(4), .BLINK_CYCLES(3)) u_dut (
      .clock          (clock),
      .reset          (reset),
      .button_pressed (button_pressed),
      .led            (led),
      .mode           (mode),
`ifdef LED_PRESS_COUNT_EN
      .press_count    (),
`endif
      .press_ignored  (press_ignored)
   );

`ifdef LED_PRESS_COUNT_EN
   logic [1:0]  bp_pc = 2'b00;
   logic [1:0]  led_pc;
   logic [3:0]  mode_pc;
   logic [1:0]  ign_pc;
   logic [15:0] cnt_pc;

   button_led_ctrl #(.BUTTON_COUNT(2), .LOCKOUT_CYCLES(1), .BLINK_CYCLES(3)) u_pc (
      .clock          (clock),
      .reset          (reset),
      .button_pressed (bp_pc),
      .led            (led_pc),
      .mode           (mode_pc),
      .press_count    (cnt_pc),
      .press_ignored  (ign_pc)
   );
`endif

   always @(posedge clock) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic step(input logic [1:0] b);
      button_pressed = b;
      @(posedge clock);
      #1;
      button_pressed = 2'b00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2'b00);
      step(2'b00);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(2'b00);
         checks++;
         if ({led, mode, press_ignored} !== 8'h00) begin
            errors++;
            $display("FAIL idle_%0d: led=%b mode=%b ign=%b, expected all zero", i, led, mode, press_ignored);
         end
      end
   endtask

   task automatic test_single_press();
      do_reset();
      repeat (4) step(2'b00);
      step(2'b01);
      checks++;
      if (mode !== 4'b0001 || led !== 2'b00) begin
         errors++;
         $display("FAIL single_mode: mode=%b led=%b, expected mode=0001 led=00", mode, led);
      end
      step(2'b00);
      checks++;
      if (mode !== 4'b0001 || led !== 2'b01 || press_ignored !== 2'b00) begin
         errors++;
         $display("FAIL single_led: mode=%b led=%b ign=%b, expected 0001 01 00", mode, led, press_ignored);
      end
   endtask

   task automatic test_lockout();
      logic [1:0] exp_ign [5];
      logic [3:0] exp_mode [5];
      logic [1:0] stim [5];
      stim     = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
      exp_ign  = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
      exp_mode = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(stim[i]);
         checks++;
         if (press_ignored !== exp_ign[i] || mode !== exp_mode[i]) begin
            errors++;
            $display("FAIL lockout_%0d: ign=%b mode=%b, expected ign=%b mode=%b",
                     i, press_ignored, mode, exp_ign[i], exp_mode[i]);
         end
      end
      step(2'b00);
      checks++;
      if (press_ignored !== 2'b00) begin
         errors++;
         $display("FAIL lockout_ign_clear: ign=%b, expected 00", press_ignored);
      end
   endtask

   task automatic test_blink();
      logic exp_led;
      do_reset();
      step(2'b01);
      repeat (3) step(2'b00);
      step(2'b01);
      checks++;
      if (mode !== 4'b0010) begin
         errors++;
         $display("FAIL blink_mode: mode=%b, expected 0010", mode);
      end
      for (int i = 0; i < 12; i++) begin
         step(2'b00);
         exp_led = (((cyc - 1) / 3) % 2) != 0;
         checks++;
         if (led !== {1'b0, exp_led}) begin
            errors++;
            $display("FAIL blink_led_%0d: led=%b, expected %b", i, led, {1'b0, exp_led});
         end
      end
      step(2'b01);
      checks++;
      if (mode !== 4'b0000) begin
         errors++;
         $display("FAIL blink_off_mode: mode=%b, expected 0000", mode);
      end
      step(2'b00);
      checks++;
      if (led !== 2'b00) begin
         errors++;
         $display("FAIL blink_off_led: led=%b, expected 00", led);
      end
   endtask

   task automatic test_simultaneous_reset();
      do_reset();
      step(2'b11);
      checks++;
      if (mode !== 4'b0101) begin
         errors++;
         $display("FAIL simul_mode: mode=%b, expected 0101", mode);
      end
      step(2'b00);
      reset = 1'b1;
      step(2'b11);
      reset = 1'b0;
      checks++;
      if ({led, mode, press_ignored} !== 8'h00) begin
         errors++;
         $display("FAIL reset_clear: led=%b mode=%b ign=%b, expected all zero", led, mode, press_ignored);
      end
      step(2'b11);
      checks++;
      if (mode !== 4'b0101 || press_ignored !== 2'b00) begin
         errors++;
         $display("FAIL post_reset_press: mode=%b ign=%b, expected 0101 00", mode, press_ignored);
      end
   endtask

`ifdef LED_PRESS_COUNT_EN
   task automatic test_press_count();
      do_reset();
      bp_pc = 2'b10;
      repeat (258) step(2'b00);
      bp_pc = 2'b00;
      step(2'b00);
      checks++;
      if (cnt_pc !== 16'h0200 || mode_pc !== 4'b0000 || ign_pc !== 2'b00) begin
         errors++;
         $display("FAIL press_count: cnt=%h mode=%b ign=%b, expected 0200 0000 00", cnt_pc, mode_pc, ign_pc);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_press();
      test_lockout();
      test_blink();
      test_simultaneous_reset();
`ifdef LED_PRESS_COUNT_EN
      test_press_count();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
